in_feature_loader: RTL and testbench
====================================

# in_feature_loader

Front-end stage that fills the dual-port `in_feature` RAM feeding layer 1, then starts the CNN. It accepts a pixel stream through a valid/ready handshake and writes each pixel to consecutive RAM addresses. After a full frame it pulses the network reset and holds the network enable until the final layer reports done. It sits directly upstream of `layer_1` and owns the RAM write ports and the network `enable`/`reset`.

## Interface

Parameters:
- `ADDR_WIDTH`, default 10: in_feature RAM address width.
- `DATA_WIDTH`, default 16: pixel width, fixed-point as used by the network.
- `NUM_PIXELS`, default 784: pixels per frame. Must be at most 2^ADDR_WIDTH, and even when the packed mode is compiled in.
- `LANES`, default 1: derived, not user-set. It is 2 with `IN_FEATURE_LOADER_PACK2_EN` and 1 without.

Ports:
- `clock` in, 1 bit: the single clock.
- `reset` in, 1 bit: synchronous, active-low.
- `frame_start` in, 1 bit: begin loading a frame. Sampled only in IDLE.
- `pix_valid` in, 1 bit: a pixel word is presented.
- `pix_data` in, DATA_WIDTH*LANES bits: pixel word. Lane 0 is in the LSBs.
- `pix_ready` out, 1 bit: the loader accepts the word this cycle.
- `ram_addra` out, ADDR_WIDTH bits: RAM port A address.
- `ram_addrb` out, ADDR_WIDTH bits: RAM port B address.
- `ram_data_a` out, DATA_WIDTH bits: RAM port A write data.
- `ram_data_b` out, DATA_WIDTH bits: RAM port B write data.
- `ram_wren_a` out, 1 bit: port A write strobe.
- `ram_wren_b` out, 1 bit: port B write strobe.
- `net_enable` out, 1 bit: drives the CNN top-level `enable`.
- `net_reset` out, 1 bit: drives the CNN top-level `reset`, active-high.
- `net_done` in, 1 bit: last-layer done from the network.
- `busy` out, 1 bit: high whenever the state is not IDLE.
- `frame_done` out, 1 bit: one-cycle pulse when the network finishes.
- `pix_count` out, ADDR_WIDTH+1 bits: pixels accepted in the current frame.

## Operation

States are IDLE, LOAD, KICK and RUN.

- **IDLE**
  - `pix_ready`=0.
  - `frame_start`=1 moves to LOAD and clears `pix_count` to 0.
  - `pix_valid` in IDLE is ignored; no write occurs.
- **LOAD**
  - `pix_ready`=1.
  - A handshake (`pix_valid` && `pix_ready`) writes lane 0 to address `pix_count`.
  - In PACK2 mode it also writes lane 1 to address `pix_count`+1.
  - Each handshake adds LANES to `pix_count`.
  - On the handshake that makes `pix_count` reach NUM_PIXELS, `pix_ready` drops in the next cycle and the state moves to KICK.
- **KICK**
  - Lasts exactly 2 cycles.
  - `net_reset`=1 and `net_enable`=0 for both cycles.
  - Then moves to RUN.
- **RUN**
  - `net_reset`=0 and `net_enable`=1.
  - `net_done`=1 moves to IDLE and pulses `frame_done` in the following cycle; `net_enable` deasserts in that same cycle.
  - `net_done` is ignored in every other state.

Additional rules:
- `frame_start` is ignored in LOAD, KICK and RUN.
- Addresses never wrap: accepted pixels go to addresses 0..NUM_PIXELS-1 only.
- Write strobes are 0 in every cycle with no handshake. Addresses and data hold their last values.
- `net_reset` is 1 in IDLE and LOAD, so the network is held in reset while the RAM is being written.

## Timing

- Writes are registered. A handshake in cycle n puts `ram_addr*`, `ram_data*` and `ram_wren*`=1 on the outputs in cycle n+1.
- A last handshake in cycle n gives:
  - cycle n+1: final write issued, state KICK;
  - cycles n+1 and n+2: `net_reset`=1;
  - cycle n+3: `net_enable`=1.
- `net_done` sampled 1 in cycle m gives `frame_done`=1 and `net_enable`=0 in cycle m+1, with the state back in IDLE.
- Values while `reset`=0, and therefore at the first cycle after release:
  - state IDLE;
  - `pix_ready`=0, `ram_wren_a`=0, `ram_wren_b`=0;
  - all addresses and data 0;
  - `pix_count`=0;
  - `net_enable`=0, `net_reset`=1;
  - `busy`=0, `frame_done`=0.
- Reset asserted mid-frame (LOAD or RUN) aborts immediately on the next edge:
  - the partial frame is discarded;
  - any write pending in the registered stage is dropped.
- Throughput is one word per cycle at sustained `pix_valid`=1. There are no bubbles inside LOAD.

## Configuration

- `IN_FEATURE_LOADER_PACK2_EN` defined:
  - LANES=2; `pix_data` is 2*DATA_WIDTH bits.
  - Both RAM ports write each handshake: port A at an even address, port B at the next odd address.
  - A frame takes NUM_PIXELS/2 handshakes.
- Not defined:
  - LANES=1; only port A writes.
  - `ram_wren_b` is tied to 0; `ram_addrb` and `ram_data_b` are tied to 0.
  - A frame takes NUM_PIXELS handshakes.

## Test plan

1. **Reset values.** Hold `reset`=0 for 3 cycles with `pix_valid`=1, then release. Required: `pix_ready`=0, `net_reset`=1, `net_enable`=0, `busy`=0, and no RAM write.
2. **Full frame, LANES=1.** Pulse `frame_start`, then drive 784 pixels with values 0..783 at `pix_valid`=1 every cycle. Required:
   - RAM address k holds k;
   - `net_reset` is high exactly 2 cycles after the last write is issued;
   - `net_enable`=1 three cycles after the last handshake.
3. **Stalled stream.** Toggle `pix_valid` with a 1-on/2-off pattern. Required:
   - `pix_count` increments only on handshake cycles;
   - addresses are contiguous with no gaps;
   - `frame_done` appears only after `net_done` is driven.
4. **Done handshake.** In RUN, drive `net_done` in cycle 100. Required:
   - `frame_done`=1 for the single cycle 101;
   - `net_enable`=0 at cycle 101;
   - a `frame_start` pulsed at cycle 99 had no effect;
   - a `frame_start` at cycle 102 starts a new LOAD.
5. **Reset mid-LOAD.** Assert `reset` after 300 pixels. Required:
   - `pix_count` is 0 on the next cycle, the state is IDLE, and no further writes occur;
   - a subsequent frame writes from address 0.
6. **PACK2 build.** Drive 392 words with lane 0 = 2i and lane 1 = 2i+1. Required: RAM address j holds j for j = 0..783, and both write strobes fire in every handshake cycle.

Source files
------------

// File: rtl/in_feature_loader_if.sv
`timescale 1ns/1ps
// Pixel stream, in_feature RAM write ports and CNN control for in_feature_loader.
// Lane count follows IN_FEATURE_LOADER_PACK2_EN (2 lanes when defined, else 1).
interface in_feature_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
);
`ifdef IN_FEATURE_LOADER_PACK2_EN
  localparam int unsigned LANES = 2;
`else
  localparam int unsigned LANES = 1;
`endif

  logic                          frame_start;
  logic                          pix_valid;
  logic [DATA_WIDTH*LANES-1:0]   pix_data;
  logic                          pix_ready;
  logic [ADDR_WIDTH-1:0]         ram_addra;
  logic [ADDR_WIDTH-1:0]         ram_addrb;
  logic [DATA_WIDTH-1:0]         ram_data_a;
  logic [DATA_WIDTH-1:0]         ram_data_b;
  logic                          ram_wren_a;
  logic                          ram_wren_b;
  logic                          net_enable;
  logic                          net_reset;
  logic                          net_done;
  logic                          busy;
  logic                          frame_done;
  logic [ADDR_WIDTH:0]           pix_count;

  modport master (
    output frame_start, pix_valid, pix_data, net_done,
    input  pix_ready, ram_addra, ram_addrb, ram_data_a, ram_data_b,
           ram_wren_a, ram_wren_b, net_enable, net_reset, busy,
           frame_done, pix_count
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, net_done,
    output pix_ready, ram_addra, ram_addrb, ram_data_a, ram_data_b,
           ram_wren_a, ram_wren_b, net_enable, net_reset, busy,
           frame_done, pix_count
  );
endinterface

// File: rtl/in_feature_loader.sv
`timescale 1ns/1ps
// Loads one frame of pixels into the in_feature RAM, then kicks and runs the CNN.
// IN_FEATURE_LOADER_PACK2_EN: two pixels per handshake, written on both RAM ports.
module in_feature_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PIXELS = 784
) (
  input  logic                 clock,
  input  logic                 reset,
  in_feature_loader_if.slave   bus
);
`ifdef IN_FEATURE_LOADER_PACK2_EN
  localparam int unsigned LANES = 2;
`else
  localparam int unsigned LANES = 1;
`endif
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] LANE_INC   = CNT_W'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_KICK, S_RUN} state_t;

  state_t                r_state;
  logic                  r_kick;
  logic                  r_pix_ready;
  logic                  r_busy;
  logic                  r_net_enable;
  logic                  r_net_reset;
  logic                  r_frame_done;
  logic [CNT_W-1:0]      r_pix_count;
  logic [ADDR_WIDTH-1:0] r_addra;
  logic [DATA_WIDTH-1:0] r_data_a;
  logic                  r_wren_a;
`ifdef IN_FEATURE_LOADER_PACK2_EN
  logic [ADDR_WIDTH-1:0] r_addrb;
  logic [DATA_WIDTH-1:0] r_data_b;
  logic                  r_wren_b;
`endif

  logic                  w_hs;
  logic [CNT_W-1:0]      w_next_count;

  // r_pix_ready is high only in LOAD, so it also qualifies the handshake.
  assign w_hs         = bus.pix_valid & r_pix_ready;
  assign w_next_count = r_pix_count + LANE_INC;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_kick       <= 1'b0;
      r_pix_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_net_enable <= 1'b0;
      r_net_reset  <= 1'b1;
      r_frame_done <= 1'b0;
      r_pix_count  <= '0;
      r_addra      <= '0;
      r_data_a     <= '0;
      r_wren_a     <= 1'b0;
`ifdef IN_FEATURE_LOADER_PACK2_EN
      r_addrb      <= '0;
      r_data_b     <= '0;
      r_wren_b     <= 1'b0;
`endif
    end else begin
      r_wren_a     <= 1'b0;
`ifdef IN_FEATURE_LOADER_PACK2_EN
      r_wren_b     <= 1'b0;
`endif
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.frame_start) begin
            r_state     <= S_LOAD;
            r_pix_count <= '0;
            r_pix_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            r_addra     <= r_pix_count[ADDR_WIDTH-1:0];
            r_data_a    <= bus.pix_data[DATA_WIDTH-1:0];
            r_wren_a    <= 1'b1;
`ifdef IN_FEATURE_LOADER_PACK2_EN
            r_addrb     <= r_pix_count[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
            r_data_b    <= bus.pix_data[2*DATA_WIDTH-1:DATA_WIDTH];
            r_wren_b    <= 1'b1;
`endif
            r_pix_count <= w_next_count;
            if (w_next_count == LAST_COUNT) begin
              r_state     <= S_KICK;
              r_pix_ready <= 1'b0;
              r_kick      <= 1'b0;
            end
          end
        end
        // Two cycles of network reset before enabling it.
        S_KICK: begin
          if (r_kick) begin
            r_state      <= S_RUN;
            r_net_reset  <= 1'b0;
            r_net_enable <= 1'b1;
          end else begin
            r_kick <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.net_done) begin
            r_state      <= S_IDLE;
            r_net_enable <= 1'b0;
            r_net_reset  <= 1'b1;
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_ready  = r_pix_ready;
  assign bus.busy       = r_busy;
  assign bus.net_enable = r_net_enable;
  assign bus.net_reset  = r_net_reset;
  assign bus.frame_done = r_frame_done;
  assign bus.pix_count  = r_pix_count;
  assign bus.ram_addra  = r_addra;
  assign bus.ram_data_a = r_data_a;
  assign bus.ram_wren_a = r_wren_a;
`ifdef IN_FEATURE_LOADER_PACK2_EN
  assign bus.ram_addrb  = r_addrb;
  assign bus.ram_data_b = r_data_b;
  assign bus.ram_wren_b = r_wren_b;
`else
  assign bus.ram_addrb  = '0;
  assign bus.ram_data_b = '0;
  assign bus.ram_wren_b = 1'b0;
`endif

endmodule

// File: tb/tb_in_feature_loader.sv
`timescale 1ns/1ps
// Directed bench for in_feature_loader: reset, full/stalled frames, done handshake,
// mid-frame reset; PACK2 lane layout when IN_FEATURE_LOADER_PACK2_EN is defined.
module tb_in_feature_loader;
  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 16;
  localparam int unsigned NPIX = 784;
`ifdef IN_FEATURE_LOADER_PACK2_EN
  localparam int unsigned LANES = 2;
`else
  localparam int unsigned LANES = 1;
`endif
  localparam int unsigned WORDS = NPIX / LANES;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  in_feature_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  in_feature_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PIXELS(NPIX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // RAM model and port-A address log, filled from the write strobes.
  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [AW-1:0] alog [0:8191];
  int wr_cnt  = 0;
  int wrb_cnt = 0;

  always @(negedge clock) begin
    if (bus.ram_wren_a === 1'b1) begin
      mem[bus.ram_addra]   <= bus.ram_data_a;
      alog[wr_cnt & 8191]  <= bus.ram_addra;
      wr_cnt               <= wr_cnt + 1;
    end
    if (bus.ram_wren_b === 1'b1) begin
      mem[bus.ram_addrb]   <= bus.ram_data_b;
      wrb_cnt              <= wrb_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams n_words words; checks count and registered write on every handshake.
  task automatic drive_frame(input int n_words, input int base, input bit stall, output int bad);
    bad = 0;
    for (int i = 0; i < n_words; i++) begin
      bus.pix_valid = 1'b1;
      for (int l = 0; l < int'(LANES); l++)
        bus.pix_data[l*DW +: DW] = DW'(base + int'(LANES) * i + l);
      tick();
      if (32'(bus.pix_count) != LANES * 32'(i + 1)) bad++;
      if (bus.ram_wren_a !== 1'b1 || 32'(bus.ram_addra) != LANES * 32'(i)) bad++;
`ifdef IN_FEATURE_LOADER_PACK2_EN
      if (bus.ram_wren_b !== 1'b1 || 32'(bus.ram_addrb) != LANES * 32'(i) + 1) bad++;
`endif
      if (stall) begin
        bus.pix_valid = 1'b0;
        repeat (2) begin
          tick();
          if (bus.ram_wren_a !== 1'b0 || 32'(bus.pix_count) != LANES * 32'(i + 1)) bad++;
        end
      end
    end
    bus.pix_valid = 1'b0;
  endtask

  // RAM holds base+k at k; port A addresses of the frame were 0, LANES, 2*LANES ...
  task automatic check_frame(input int base, input int wbase, input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < int'(NPIX); k++)
      if (mem[k] !== DW'(base + k)) bad++;
    chk({tag, "_mem"}, 32'(bad), 32'd0);
    bad = 0;
    for (int k = 0; k < int'(WORDS); k++)
      if (32'(alog[(wbase + k) & 8191]) != LANES * 32'(k)) bad++;
    chk({tag, "_addr_seq"}, 32'(bad), 32'd0);
    chk({tag, "_nwrites"}, 32'(wr_cnt - wbase), 32'(WORDS));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int wb;
    int wbb;
    reset           = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b1;
    bus.pix_data    = '0;
    bus.net_done    = 1'b0;

    // Reset held with pix_valid high, then released.
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("t1_pix_ready",  32'(bus.pix_ready),  32'd0);
    chk("t1_net_reset",  32'(bus.net_reset),  32'd1);
    chk("t1_net_enable", 32'(bus.net_enable), 32'd0);
    chk("t1_busy",       32'(bus.busy),       32'd0);
    chk("t1_frame_done", 32'(bus.frame_done), 32'd0);
    chk("t1_pix_count",  32'(bus.pix_count),  32'd0);
    chk("t1_addra",      32'(bus.ram_addra),  32'd0);
    chk("t1_addrb",      32'(bus.ram_addrb),  32'd0);
    chk("t1_data_a",     32'(bus.ram_data_a), 32'd0);
    tick();
    chk("t1_no_write",   32'(wr_cnt + wrb_cnt), 32'd0);
    bus.pix_valid = 1'b0;

    // Full frame at one word per cycle.
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("t2_ready",      32'(bus.pix_ready),  32'd1);
    chk("t2_busy",       32'(bus.busy),       32'd1);
    chk("t2_reset_load", 32'(bus.net_reset),  32'd1);
    chk("t2_count0",     32'(bus.pix_count),  32'd0);
    wb  = wr_cnt;
    wbb = wrb_cnt;
    drive_frame(int'(WORDS), 0, 1'b0, bad);
    chk("t2_stream", 32'(bad), 32'd0);
    chk("t2_n1_ready",  32'(bus.pix_ready),  32'd0);
    chk("t2_n1_reset",  32'(bus.net_reset),  32'd1);
    chk("t2_n1_enable", 32'(bus.net_enable), 32'd0);
    tick();
    chk("t2_n2_reset",  32'(bus.net_reset),  32'd1);
    chk("t2_n2_enable", 32'(bus.net_enable), 32'd0);
    chk("t2_n2_wren",   32'(bus.ram_wren_a), 32'd0);
    tick();
    chk("t2_n3_reset",  32'(bus.net_reset),  32'd0);
    chk("t2_n3_enable", 32'(bus.net_enable), 32'd1);
    check_frame(0, wb, "t2");
`ifdef IN_FEATURE_LOADER_PACK2_EN
    chk("t6_portb_writes", 32'(wrb_cnt - wbb), 32'(WORDS));
`endif

    // Done handshake; frame_start in RUN is ignored.
    repeat (3) tick();
    chk("t4_run_enable", 32'(bus.net_enable), 32'd1);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("t4_fs_ignored_busy",  32'(bus.busy),      32'd1);
    chk("t4_fs_ignored_ready", 32'(bus.pix_ready), 32'd0);
    bus.net_done = 1'b1;
    tick();
    bus.net_done = 1'b0;
    chk("t4_frame_done", 32'(bus.frame_done), 32'd1);
    chk("t4_enable_off", 32'(bus.net_enable), 32'd0);
    chk("t4_idle_busy",  32'(bus.busy),       32'd0);
    chk("t4_idle_reset", 32'(bus.net_reset),  32'd1);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("t4_done_pulse", 32'(bus.frame_done), 32'd0);
    chk("t4_new_load",   32'(bus.pix_ready),  32'd1);
    chk("t4_count_clr",  32'(bus.pix_count),  32'd0);

    // Stalled stream, 1-on/2-off; net_done ignored while loading.
    bus.net_done = 1'b1;
    tick();
    bus.net_done = 1'b0;
    chk("t3_done_in_load_ready", 32'(bus.pix_ready),  32'd1);
    chk("t3_done_in_load_fd",    32'(bus.frame_done), 32'd0);
    wb = wr_cnt;
    drive_frame(int'(WORDS), 'h1000, 1'b1, bad);
    chk("t3_stream", 32'(bad), 32'd0);
    chk("t3_enable", 32'(bus.net_enable), 32'd1);
    check_frame('h1000, wb, "t3");
    bad = 0;
    repeat (4) begin
      tick();
      if (bus.frame_done !== 1'b0) bad++;
    end
    chk("t3_no_early_done", 32'(bad), 32'd0);
    bus.net_done = 1'b1;
    tick();
    bus.net_done = 1'b0;
    chk("t3_frame_done", 32'(bus.frame_done), 32'd1);
    tick();
    chk("t3_done_single", 32'(bus.frame_done), 32'd0);
    bus.net_done = 1'b1;
    tick();
    bus.net_done = 1'b0;
    chk("t3_done_in_idle", 32'(bus.frame_done), 32'd0);

    // Reset in the middle of a frame, with a handshake on the reset cycle.
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    wb = wr_cnt;
    drive_frame(300 / int'(LANES), 'h2000, 1'b0, bad);
    chk("t5_stream", 32'(bad), 32'd0);
    bus.pix_valid = 1'b1;
    reset         = 1'b0;
    tick();
    reset = 1'b1;
    chk("t5_count",     32'(bus.pix_count),  32'd0);
    chk("t5_busy",      32'(bus.busy),       32'd0);
    chk("t5_ready",     32'(bus.pix_ready),  32'd0);
    chk("t5_wren",      32'(bus.ram_wren_a), 32'd0);
    chk("t5_addra",     32'(bus.ram_addra),  32'd0);
    chk("t5_net_reset", 32'(bus.net_reset),  32'd1);
    chk("t5_partial_writes", 32'(wr_cnt - wb), 32'(300 / LANES));
    wb = wr_cnt;
    repeat (3) tick();
    bus.pix_valid = 1'b0;
    chk("t5_no_writes", 32'(wr_cnt - wb), 32'd0);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    wb = wr_cnt;
    drive_frame(int'(WORDS), 'h3000, 1'b0, bad);
    chk("t5_refill_stream", 32'(bad), 32'd0);
    tick();
    tick();
    chk("t5_refill_enable", 32'(bus.net_enable), 32'd1);
    check_frame('h3000, wb, "t5");

`ifndef IN_FEATURE_LOADER_PACK2_EN
    chk("portb_never_writes", 32'(wrb_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
